// File: rtl/uart_pkg.sv
// uart_pkg: frame constants, receiver FSM states and baud divider helper.
// Shared by the UART receive path and a future matching transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    // Clock cycles per bit, rounded to nearest.
    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small power-of-two byte FIFO with head-data output.
// Push while full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [7:0]               wr_data_i,
    output logic                     full_o,
    input  logic                     rd_en_i,
    output logic                     empty_o,
    output logic [7:0]               rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_wr;
    logic          do_rd;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == CW'(DEPTH));
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign rd_data_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];
    assign count_o   = cnt_q;

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 UART receiver for the SoC txd line, with a
// byte FIFO and valid/ready output for on-board consumers.
module uart_rx_monitor
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 8000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock_clock,
    input  logic       resetN,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = uart_div(CLK_HZ, BAUD);
    localparam int TW  = $clog2(DIV);
    localparam logic [TW-1:0] HALF_LD = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] FULL_LD = TW'(DIV - 1);
    localparam logic [2:0]    LAST_IX = 3'(DATA_BITS - 1);

    if (DIV < 16 || STOP_BITS != 1) begin : g_bad_div
        $error("uart_rx_monitor: DIV must be at least 16");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_monitor: FIFO_DEPTH must be a power of two >= 2");
    end

    logic           sync1_q;
    logic           sync2_q;
    logic [1:0]     svld_q;
    logic           seen_hi_q;
    uart_rx_state_t state_q, state_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     sh_q, sh_d;
    logic           ferr_q, ferr_d;
    logic           ovr_q, ovr_d;

    logic           rxs;
    logic           tick;
    logic           push_good;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
    logic           cnt_unused;

    assign rxs        = sync2_q;
    assign tick       = (tmr_q == '0);
    assign rx_valid   = !fifo_empty;
    assign pop        = rx_valid && rx_ready;
    assign busy       = (state_q != IDLE);
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign cnt_unused = ^fifo_cnt;

    always_comb begin
        state_d   = state_q;
        tmr_d     = tick ? tmr_q : tmr_q - TW'(1);
        idx_d     = idx_q;
        sh_d      = sh_q;
        push_good = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Only a fall seen after a genuine high level starts a frame.
                if (seen_hi_q && !rxs) begin
                    tmr_d   = HALF_LD;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        tmr_d   = FULL_LD;
                        idx_d   = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sh_d  = {rxs, sh_q[7:1]};
                    tmr_d = FULL_LD;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == LAST_IX) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rxs) begin
                        push_good = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ovr_d = push_good && fifo_full && !pop;
    end

    always_ff @(posedge clock_clock or negedge resetN) begin
        if (!resetN) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            svld_q    <= '0;
            seen_hi_q <= 1'b0;
            state_q   <= IDLE;
            tmr_q     <= '0;
            idx_q     <= '0;
            sh_q      <= '0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= uart_rxd;
            sync2_q   <= sync1_q;
            svld_q    <= {svld_q[0], 1'b1};
            seen_hi_q <= seen_hi_q | (svld_q[1] & sync2_q);
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clock_clock),
        .rst_ni   (resetN),
        .wr_en_i  (push_good),
        .wr_data_i(sh_d),
        .full_o   (fifo_full),
        .rd_en_i  (rx_ready),
        .empty_o  (fifo_empty),
        .rd_data_o(rx_data),
        .count_o  (fifo_cnt)
    );

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: directed and randomized 8N1 frames against a
// queue-based model of the receiver's byte stream and event counts.
module tb_uart_rx_monitor;

    localparam int CLK_HZ = 8000000;
    localparam int BAUD   = 115200;
    localparam int DEPTH  = 4;
    localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       rxd   = 1'b1;
    logic       rdy   = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_chk  = 0;
    int n_err  = 0;
    int n_ferr = 0;
    int n_ovr  = 0;
    int base_f;
    int base_o;
    int nbad;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_monitor #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock_clock(clk),
        .resetN     (rst_n),
        .uart_rxd   (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rdy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_byte"}, got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Transmit one frame; line is left at the stop-bit level.
    task automatic send(input logic [7:0] b, input logic stp, input int per);
        rxd = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (per) @(negedge clk);
        end
        rxd = stp;
        repeat (per) @(negedge clk);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (rx_valid && rdy) got_q.push_back(rx_data);
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
    end

    initial begin
        logic [7:0] b;
        logic       bad;
        int         per;
        int         lo;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // First byte and its exact latency.
        rdy = 1'b1;
        fork
            send(8'hA5, 1'b1, DIV);
            begin
                repeat (657) @(negedge clk);
                #1 chk("a5_pre_valid", rx_valid, 0);
                @(negedge clk);
                #1;
                chk("a5_valid", rx_valid, 1);
                chk("a5_data", rx_data, 8'hA5);
                chk("a5_ferr", frame_err, 0);
            end
        join
        repeat (20) @(negedge clk);
        exp_q.push_back(8'hA5);
        cmp_q("a5");

        // Short glitch is a false start.
        base_f = n_ferr;
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        #1 chk("glitch_busy_hi", busy, 1);
        repeat (20) @(negedge clk);
        #1 chk("glitch_busy_lo", busy, 0);
        repeat (10 * DIV) @(negedge clk);
        cmp_q("glitch");
        chk("glitch_ferr", n_ferr - base_f, 0);

        // Bad stop bit followed by a held-low line.
        base_f = n_ferr;
        send(8'h3C, 1'b0, DIV);
        repeat (10 * DIV) @(negedge clk);
        #1 chk("break_busy", busy, 1);
        repeat (10 * DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("break_idle", busy, 0);
        chk("break_ferr", n_ferr - base_f, 1);
        chk("break_empty", rx_valid, 0);
        @(negedge clk);
        send(8'h55, 1'b1, DIV);
        repeat (10) @(negedge clk);
        exp_q.push_back(8'h55);
        cmp_q("after_break");

        // Overflow with the consumer stalled.
        rdy = 1'b0;
        base_o = n_ovr;
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, DIV);
        repeat (10) @(negedge clk);
        #1;
        chk("ovr_count", n_ovr - base_o, (5 > DEPTH) ? 5 - DEPTH : 0);
        chk("ovr_valid", rx_valid, 1);
        @(negedge clk);
        rdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("pop_valid", rx_valid, 1);
            chk("pop_data", rx_data, 32'(i + 1));
            @(negedge clk);
        end
        #1 chk("pop_empty", rx_valid, 0);
        for (int i = 1; i <= DEPTH && i <= 5; i++) exp_q.push_back(8'(i));
        cmp_q("ovr");
        @(negedge clk);

        // Pop exactly on the stop-sample edge while full.
        rdy = 1'b0;
        base_o = n_ovr;
        send(8'h11, 1'b1, DIV);
        send(8'h22, 1'b1, DIV);
        send(8'h33, 1'b1, DIV);
        send(8'h44, 1'b1, DIV);
        repeat (5) @(negedge clk);
        fork
            send(8'h99, 1'b1, DIV);
            begin
                repeat (657) @(negedge clk);
                rdy = 1'b1;
                @(negedge clk);
                rdy = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        #1 chk("full_pop_ovr", n_ovr - base_o, 0);
        @(negedge clk);
        rdy = 1'b1;
        repeat (10) @(negedge clk);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h99);
        cmp_q("full_pop");

        // Reset in the middle of a frame.
        rdy = 1'b0;
        send(8'h5A, 1'b1, DIV);
        repeat (5) @(negedge clk);
        #1 chk("pre_rst_valid", rx_valid, 1);
        @(negedge clk);
        base_f = n_ferr;
        fork
            send(8'h00, 1'b1, DIV);
            begin
                repeat (3 * DIV + 10) @(negedge clk);
                #1 chk("mid_busy", busy, 1);
                rst_n = 1'b0;
                #1;
                chk("mid_rst_valid", rx_valid, 0);
                chk("mid_rst_data", rx_data, 0);
                chk("mid_rst_busy", busy, 0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        exp_q.delete();
        repeat (30) @(negedge clk);
        #1 chk("aborted_valid", rx_valid, 0);
        @(negedge clk);
        rdy = 1'b1;
        send(8'h7E, 1'b1, DIV);
        repeat (10) @(negedge clk);
        exp_q.push_back(8'h7E);
        cmp_q("after_rst");
        chk("after_rst_ferr", n_ferr - base_f, 0);

        // Random frames with small baud mismatch and bad stop bits.
        base_f = n_ferr;
        nbad = 0;
        for (int f = 0; f < 12; f++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            per = DIV - 1 + int'($urandom_range(0, 2));
            send(b, !bad, per);
            if (bad) begin
                nbad++;
                rxd = 1'b1;
                lo = 4;
            end else begin
                exp_q.push_back(b);
                lo = 0;
            end
            repeat ($urandom_range(lo, 40)) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        cmp_q("rand");
        chk("rand_ferr", n_ferr - base_f, nbad);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
